// File: rtl/jtframe_mcu_mem.sv
// jtframe_mcu_mem
//   Memory resources for an MCU subsystem:
//   - a true dual-port shared RAM (port 0: MCU, port 1: main CPU), registered
//     reads returning old data on read-during-write, port 0 wins a same-address
//     same-edge write collision;
//   - a single-port internal RAM gated by int_cen;
//   - an edge-triggered flag with clear/set priority, gated by ff_cen.
// Ports:
//   clk, rst_n           clock and synchronous active-low reset (flag only)
//   sh_addr0/1, sh_data0/1, sh_we0/1, sh_q0/1   shared RAM ports
//   int_cen, int_addr, int_data, int_we, int_q  internal RAM
//   ff_cen, ff_sigedge, ff_din, ff_clr, ff_set, ff_q, ff_qn  flag
module jtframe_mcu_mem #(
  parameter int DW     = 8,
  parameter int SH_AW  = 9,
  parameter int INT_AW = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [SH_AW-1:0]  sh_addr0,
  input  logic [DW-1:0]     sh_data0,
  input  logic              sh_we0,
  output logic [DW-1:0]     sh_q0,
  input  logic [SH_AW-1:0]  sh_addr1,
  input  logic [DW-1:0]     sh_data1,
  input  logic              sh_we1,
  output logic [DW-1:0]     sh_q1,
  input  logic              int_cen,
  input  logic [INT_AW-1:0] int_addr,
  input  logic [DW-1:0]     int_data,
  input  logic              int_we,
  output logic [DW-1:0]     int_q,
  input  logic              ff_cen,
  input  logic              ff_sigedge,
  input  logic              ff_din,
  input  logic              ff_clr,
  input  logic              ff_set,
  output logic              ff_q,
  output logic              ff_qn
);

  logic [DW-1:0] sh_mem  [2**SH_AW];
  logic [DW-1:0] int_mem [2**INT_AW];
  logic          ff_last;

  // Shared RAM. Reads sample the array before this edge's writes land, so both
  // same-port and cross-port reads on the write edge see old data. Port 0 is
  // written last so it wins a same-address collision. Unaffected by reset.
  always_ff @(posedge clk) begin
    sh_q0 <= sh_mem[sh_addr0];
    sh_q1 <= sh_mem[sh_addr1];
    if (sh_we1) sh_mem[sh_addr1] <= sh_data1;
    if (sh_we0) sh_mem[sh_addr0] <= sh_data0;
  end

  // Internal RAM: everything, including the output register, frozen when
  // int_cen is low. Unaffected by reset.
  always_ff @(posedge clk) begin
    if (int_cen) begin
      int_q <= int_mem[int_addr];
      if (int_we) int_mem[int_addr] <= int_data;
    end
  end

  // Flag. ff_last clears on reset so a trigger already high after release
  // counts as a rising edge on the first enabled cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ff_q    <= 1'b0;
      ff_last <= 1'b0;
    end else if (ff_cen) begin
      ff_last <= ff_sigedge;
      if (ff_clr)                       ff_q <= 1'b0;
      else if (ff_set)                  ff_q <= 1'b1;
      else if (ff_sigedge && !ff_last)  ff_q <= ff_din;
    end
  end

  assign ff_qn = ~ff_q;

endmodule

// File: tb/tb_jtframe_mcu_mem.sv
module tb_jtframe_mcu_mem;

  localparam int DW = 8, SH_AW = 9, INT_AW = 8;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [SH_AW-1:0]  sh_addr0, sh_addr1;
  logic [DW-1:0]     sh_data0, sh_data1;
  logic              sh_we0, sh_we1;
  logic [DW-1:0]     sh_q0, sh_q1;
  logic              int_cen, int_we;
  logic [INT_AW-1:0] int_addr;
  logic [DW-1:0]     int_data, int_q;
  logic              ff_cen, ff_sigedge, ff_din, ff_clr, ff_set, ff_q, ff_qn;

  int checks = 0;
  int failures = 0;

  jtframe_mcu_mem #(.DW(DW), .SH_AW(SH_AW), .INT_AW(INT_AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .sh_addr0(sh_addr0), .sh_data0(sh_data0), .sh_we0(sh_we0), .sh_q0(sh_q0),
    .sh_addr1(sh_addr1), .sh_data1(sh_data1), .sh_we1(sh_we1), .sh_q1(sh_q1),
    .int_cen(int_cen), .int_addr(int_addr), .int_data(int_data), .int_we(int_we),
    .int_q(int_q),
    .ff_cen(ff_cen), .ff_sigedge(ff_sigedge), .ff_din(ff_din), .ff_clr(ff_clr),
    .ff_set(ff_set), .ff_q(ff_q), .ff_qn(ff_qn)
  );

  always #5 clk = ~clk;

  // Advance one rising edge; inputs are changed and outputs sampled 1ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; ff_cen = 1'b0; ff_set = 1'b1; ff_sigedge = 1'b1; ff_din = 1'b1;
    tick();
    tick();
    checks++;
    if (ff_q !== 1'b0) begin failures++; $display("FAIL reset_q got=%b exp=0", ff_q); end
    checks++;
    if (ff_qn !== 1'b1) begin failures++; $display("FAIL reset_qn got=%b exp=1", ff_qn); end
    ff_set = 1'b0;
  endtask

  task automatic test_cross_port();
    // port 1 writes 0xA5 to 0x1F0, port 0 reads it on the next edge
    sh_we1 = 1'b1; sh_addr1 = 9'h1F0; sh_data1 = 8'hA5;
    tick();
    sh_we1 = 1'b0; sh_addr0 = 9'h1F0;
    tick();
    checks++;
    if (sh_q0 !== 8'hA5) begin failures++; $display("FAIL xport_q0 got=%h exp=a5", sh_q0); end
    checks++;
    if (sh_q1 !== 8'hA5) begin failures++; $display("FAIL xport_q1 got=%h exp=a5", sh_q1); end
    // port 0 overwrites with 0x5A: both ports see old data on that edge
    sh_we0 = 1'b1; sh_data0 = 8'h5A;
    tick();
    sh_we0 = 1'b0;
    checks++;
    if (sh_q0 !== 8'hA5) begin failures++; $display("FAIL rdw_same_q0 got=%h exp=a5", sh_q0); end
    checks++;
    if (sh_q1 !== 8'hA5) begin failures++; $display("FAIL rdw_cross_q1 got=%h exp=a5", sh_q1); end
    tick();
    checks++;
    if (sh_q0 !== 8'h5A) begin failures++; $display("FAIL new_q0 got=%h exp=5a", sh_q0); end
    checks++;
    if (sh_q1 !== 8'h5A) begin failures++; $display("FAIL new_q1 got=%h exp=5a", sh_q1); end
  endtask

  task automatic test_collision();
    sh_addr0 = 9'h005; sh_addr1 = 9'h005; sh_data0 = 8'h11; sh_data1 = 8'h22;
    sh_we0 = 1'b1; sh_we1 = 1'b1;
    tick();
    sh_we0 = 1'b0; sh_we1 = 1'b0;
    tick();
    checks++;
    if (sh_q0 !== 8'h11) begin failures++; $display("FAIL collide_q0 got=%h exp=11", sh_q0); end
    checks++;
    if (sh_q1 !== 8'h11) begin failures++; $display("FAIL collide_q1 got=%h exp=11", sh_q1); end
  endtask

  task automatic test_int_ram();
    int_cen = 1'b1; int_we = 1'b1; int_addr = 8'h80; int_data = 8'h99;
    tick();
    int_data = 8'h3C;
    tick();
    checks++;
    if (int_q !== 8'h99) begin failures++; $display("FAIL int_rdw got=%h exp=99", int_q); end
    // disabled: output holds and writes are ignored
    int_cen = 1'b0; int_we = 1'b1; int_data = 8'hFF;
    tick();
    tick();
    checks++;
    if (int_q !== 8'h99) begin failures++; $display("FAIL int_hold got=%h exp=99", int_q); end
    int_cen = 1'b1; int_we = 1'b0;
    tick();
    checks++;
    if (int_q !== 8'h3C) begin failures++; $display("FAIL int_read got=%h exp=3c", int_q); end
  endtask

  task automatic test_flag();
    rst_n = 1'b1; ff_cen = 1'b1; ff_din = 1'b1; ff_sigedge = 1'b0;
    tick();
    ff_sigedge = 1'b1;
    tick();
    checks++;
    if (ff_q !== 1'b1) begin failures++; $display("FAIL edge_q got=%b exp=1", ff_q); end
    checks++;
    if (ff_qn !== 1'b0) begin failures++; $display("FAIL edge_qn got=%b exp=0", ff_qn); end
    ff_clr = 1'b1;
    tick();
    ff_clr = 1'b0;
    tick();
    tick();
    checks++;
    if (ff_q !== 1'b0) begin failures++; $display("FAIL held_high_q got=%b exp=0", ff_q); end
    ff_sigedge = 1'b0;
    tick();
    ff_sigedge = 1'b1;
    tick();
    checks++;
    if (ff_q !== 1'b1) begin failures++; $display("FAIL retrigger_q got=%b exp=1", ff_q); end
    // disabled: clear ignored
    ff_cen = 1'b0; ff_clr = 1'b1;
    tick();
    ff_clr = 1'b0;
    checks++;
    if (ff_q !== 1'b1) begin failures++; $display("FAIL cen_hold_q got=%b exp=1", ff_q); end
    // disabled: sigedge low not sampled, so re-raising it is no edge
    ff_sigedge = 1'b0;
    tick();
    ff_cen = 1'b1; ff_sigedge = 1'b1; ff_din = 1'b0;
    tick();
    checks++;
    if (ff_q !== 1'b1) begin failures++; $display("FAIL last_hold_q got=%b exp=1", ff_q); end
    // enabled edge loads din=0
    ff_sigedge = 1'b0;
    tick();
    ff_sigedge = 1'b1;
    tick();
    checks++;
    if (ff_q !== 1'b0) begin failures++; $display("FAIL din0_q got=%b exp=0", ff_q); end
    ff_din = 1'b1;
  endtask

  task automatic test_priority();
    ff_sigedge = 1'b0;
    tick();
    ff_clr = 1'b1; ff_set = 1'b1; ff_sigedge = 1'b1;
    tick();
    checks++;
    if (ff_q !== 1'b0) begin failures++; $display("FAIL clr_prio_q got=%b exp=0", ff_q); end
    ff_clr = 1'b0; ff_set = 1'b1; ff_din = 1'b0; ff_sigedge = 1'b0;
    tick();
    ff_sigedge = 1'b1;
    tick();
    checks++;
    if (ff_q !== 1'b1) begin failures++; $display("FAIL set_prio_q got=%b exp=1", ff_q); end
    ff_set = 1'b0; ff_din = 1'b1;
  endtask

  task automatic test_reset_mid();
    // ff_q is 1 here; reset with set and a write on port 0 in flight
    rst_n = 1'b0; ff_set = 1'b1;
    sh_we0 = 1'b1; sh_addr0 = 9'h010; sh_data0 = 8'h42;
    tick();
    sh_we0 = 1'b0; ff_set = 1'b0;
    checks++;
    if (ff_q !== 1'b0) begin failures++; $display("FAIL rst_mid_q got=%b exp=0", ff_q); end
    checks++;
    if (ff_qn !== 1'b1) begin failures++; $display("FAIL rst_mid_qn got=%b exp=1", ff_qn); end
    // release with sigedge already high: first enabled edge triggers
    rst_n = 1'b1; ff_cen = 1'b1; ff_din = 1'b1; ff_sigedge = 1'b1;
    sh_addr0 = 9'h1F0; sh_addr1 = 9'h005;
    tick();
    checks++;
    if (ff_q !== 1'b1) begin failures++; $display("FAIL post_rst_edge_q got=%b exp=1", ff_q); end
    checks++;
    if (sh_q0 !== 8'h5A) begin failures++; $display("FAIL post_rst_1f0 got=%h exp=5a", sh_q0); end
    checks++;
    if (sh_q1 !== 8'h11) begin failures++; $display("FAIL post_rst_005 got=%h exp=11", sh_q1); end
    sh_addr1 = 9'h010;
    tick();
    checks++;
    if (sh_q1 !== 8'h42) begin failures++; $display("FAIL rst_write_010 got=%h exp=42", sh_q1); end
    checks++;
    if (int_q !== 8'h3C) begin failures++; $display("FAIL post_rst_int got=%h exp=3c", int_q); end
  endtask

  initial begin
    rst_n = 1'b0;
    sh_addr0 = '0; sh_addr1 = '0; sh_data0 = '0; sh_data1 = '0;
    sh_we0 = 1'b0; sh_we1 = 1'b0;
    int_cen = 1'b0; int_we = 1'b0; int_addr = '0; int_data = '0;
    ff_cen = 1'b0; ff_sigedge = 1'b0; ff_din = 1'b0; ff_clr = 1'b0; ff_set = 1'b0;
    test_reset();
    test_cross_port();
    test_collision();
    test_int_ram();
    test_flag();
    test_priority();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
